// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the period meter: FSM state encoding, channel index width, all-ones constants.
package freq_meas_pkg;

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Valid for widths up to 32; the cycle counter never gets close to that.
  function automatic logic [31:0] all_ones(input int w);
    return (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Circular priority search: first set req bit at or after ptr, purely combinational (0 cycles).
// No backpressure; the caller decides when to sample grant.
module rr_arbiter
  import freq_meas_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [ch_w(NCH)-1:0]   ptr,
  output logic [ch_w(NCH)-1:0]   grant,
  output logic                   any
);

  localparam int CHW = ch_w(NCH);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [CHW:0]     off;
  logic [CHW:0]     sum;

  // Rotate so that bit 0 of rot is req[ptr]; the lowest set bit is then the winner.
  assign dbl = {req, req};
  assign rot = NCH'(dbl >> ptr);
  assign any = |rot;

  always_comb begin
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = (CHW+1)'(i);
    end
  end

  assign sum   = {1'b0, ptr} + off;
  assign grant = (sum >= (CHW+1)'(NCH)) ? CHW'(sum - (CHW+1)'(NCH)) : sum[CHW-1:0];

endmodule

// File: rtl/freq_meas_sched.sv
// Round-robin shared period meter: averages 2^AVG_LOG2 rising-edge periods of the granted channel.
// Result one cycle after the terminating edge; requesters hold req until done, dropping it aborts.
module freq_meas_sched
  import freq_meas_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CNT_W    = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        sig,
  output logic                  busy,
  output logic [ch_w(NCH)-1:0]  grant_ch,
  output logic                  done,
  output logic [ch_w(NCH)-1:0]  done_ch,
  output logic [CNT_W-1:0]      period,
  output logic                  timeout
);

  localparam int CHW = ch_w(NCH);
  localparam int CW  = CNT_W + AVG_LOG2;
  localparam int ECW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0]  CYC_MAX = CW'(all_ones(CW));
  localparam logic [ECW-1:0] ELAST   = ECW'((1 << AVG_LOG2) - 1);

  state_t           state, state_n;
  logic [CHW-1:0]   rr_ptr, ptr_n, grant_n, done_ch_n;
  logic [CHW-1:0]   arb_grant;
  logic             arb_any;
  logic             sig_d, sig_d_n, sig_cur, edge_det;
  logic [CW-1:0]    cyc, cyc_n;
  logic [ECW-1:0]   ecnt, ecnt_n;
  logic [CNT_W-1:0] period_n;
  logic             timeout_n;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .any   (arb_any)
  );

  assign sig_cur  = sig[grant_ch];
  assign edge_det = sig_cur & ~sig_d;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    state_n   = state;
    ptr_n     = rr_ptr;
    grant_n   = grant_ch;
    done_ch_n = done_ch;
    sig_d_n   = sig_cur;
    cyc_n     = cyc;
    ecnt_n    = ecnt;
    period_n  = period;
    timeout_n = timeout;
    case (state)
      IDLE: begin
        // Preload with the winner's level so an already-high signal is not seen as an edge.
        sig_d_n = sig[arb_grant];
        if (arb_any) begin
          grant_n = arb_grant;
          ptr_n   = (arb_grant == CHW'(NCH - 1)) ? '0 : arb_grant + 1'b1;
          cyc_n   = '0;
          ecnt_n  = '0;
          state_n = ARM;
        end
      end
      ARM: begin
        if (!req[grant_ch]) begin
          state_n = IDLE;
        end else if (edge_det) begin
          cyc_n   = CW'(1);
          ecnt_n  = '0;
          state_n = COUNT;
        end else if (cyc == CYC_MAX) begin
          period_n  = '1;
          timeout_n = 1'b1;
          done_ch_n = grant_ch;
          state_n   = DONE;
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      COUNT: begin
        if (!req[grant_ch]) begin
          state_n = IDLE;
        end else if (edge_det && (ecnt == ELAST)) begin
          period_n  = CNT_W'(cyc >> AVG_LOG2);
          timeout_n = 1'b0;
          done_ch_n = grant_ch;
          state_n   = DONE;
        end else if (cyc == CYC_MAX) begin
          period_n  = '1;
          timeout_n = 1'b1;
          done_ch_n = grant_ch;
          state_n   = DONE;
        end else begin
          cyc_n = cyc + 1'b1;
          if (edge_det) ecnt_n = ecnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_ch <= '0;
      done_ch  <= '0;
      sig_d    <= 1'b0;
      cyc      <= '0;
      ecnt     <= '0;
      period   <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= ptr_n;
      grant_ch <= grant_n;
      done_ch  <= done_ch_n;
      sig_d    <= sig_d_n;
      cyc      <= cyc_n;
      ecnt     <= ecnt_n;
      period   <= period_n;
      timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_freq_meas_sched.sv
// Directed bench: table of per-channel period patterns with hand-computed averages, plus
// round-robin, timeout, abort and async-reset sequences on two parameterisations of the meter.
module tb_freq_meas_sched;

  localparam int NCH = 4;

  typedef struct {
    int ch;
    int p0, p1, p2, p3;
    int exp_period;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   req = '0;
  logic [NCH-1:0]   req2 = '0;
  logic [NCH-1:0]   sig;

  logic             busy, done, timeout;
  logic [1:0]       grant_ch, done_ch;
  logic [15:0]      period;
  logic             busy2, done2, timeout2;
  logic [1:0]       grant2, done_ch2;
  logic [3:0]       period2;

  int n_vec = 0;
  int n_bad = 0;

  int pat [NCH][4];
  bit en  [NCH];
  int cnt [NCH];
  int idx [NCH];

  vec_t tbl [6];
  int   rr_exp [3];

  freq_meas_sched #(.NCH(NCH), .CNT_W(16), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst), .req(req), .sig(sig),
    .busy(busy), .grant_ch(grant_ch), .done(done), .done_ch(done_ch),
    .period(period), .timeout(timeout)
  );

  freq_meas_sched #(.NCH(NCH), .CNT_W(4), .AVG_LOG2(0)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .sig(sig),
    .busy(busy2), .grant_ch(grant2), .done(done2), .done_ch(done_ch2),
    .period(period2), .timeout(timeout2)
  );

  always #5 clk = ~clk;

  // One-cycle high pulses; the gap between rising edges cycles through pat[c][0..3].
  initial begin
    sig = '0;
    for (int c = 0; c < NCH; c++) begin
      cnt[c] = 0;
      idx[c] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (!en[c]) begin
          sig[c] = 1'b0;
          cnt[c] = 0;
          idx[c] = 0;
        end else begin
          cnt[c] = cnt[c] + 1;
          if (cnt[c] >= pat[c][idx[c]]) begin
            sig[c] = 1'b1;
            cnt[c] = 0;
            idx[c] = (idx[c] + 1) % 4;
          end else begin
            sig[c] = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pat(input int ch, input int a, input int b, input int c, input int d);
    pat[ch][0] = a;
    pat[ch][1] = b;
    pat[ch][2] = c;
    pat[ch][3] = d;
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic wait_done2(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_done_seen"}, 32'(done2), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    set_pat(v.ch, v.p0, v.p1, v.p2, v.p3);
    en[v.ch] = 1'b1;
    @(posedge clk);
    #1 req[v.ch] = 1'b1;
    wait_done("vec", ok);
    if (ok) begin
      chk("vec_done_ch", 32'(done_ch), 32'(v.ch));
      chk("vec_grant_ch", 32'(grant_ch), 32'(v.ch));
      chk("vec_period", 32'(period), 32'(v.exp_period));
      chk("vec_timeout", 32'(timeout), 32'd0);
    end
    @(posedge clk);
    #1;
    req[v.ch] = 1'b0;
    en[v.ch]  = 1'b0;
    @(negedge clk);
    chk("vec_done_one_cycle", 32'(done), 32'd0);
    chk("vec_idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    int got;
    int ndone;

    tbl[0] = '{ch: 1, p0: 5,  p1: 5,  p2: 5,  p3: 5,  exp_period: 5};
    tbl[1] = '{ch: 0, p0: 3,  p1: 4,  p2: 3,  p3: 4,  exp_period: 3};
    tbl[2] = '{ch: 2, p0: 7,  p1: 7,  p2: 7,  p3: 7,  exp_period: 7};
    tbl[3] = '{ch: 3, p0: 6,  p1: 6,  p2: 5,  p3: 5,  exp_period: 5};
    tbl[4] = '{ch: 2, p0: 2,  p1: 2,  p2: 2,  p3: 2,  exp_period: 2};
    tbl[5] = '{ch: 1, p0: 10, p1: 11, p2: 12, p3: 13, exp_period: 11};
    rr_exp[0] = 0;
    rr_exp[1] = 2;
    rr_exp[2] = 0;
    for (int c = 0; c < NCH; c++) en[c] = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_ch", 32'(done_ch), 32'd0);
    chk("rst_grant_ch", 32'(grant_ch), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin between channels 0 and 2, each re-raising req right after its done
    set_pat(0, 4, 4, 4, 4);
    set_pat(2, 8, 8, 8, 8);
    en[0] = 1'b1;
    en[2] = 1'b1;
    @(posedge clk);
    #1;
    req[0] = 1'b1;
    req[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done("rr", ok);
      if (ok) begin
        chk("rr_done_ch", 32'(done_ch), 32'(rr_exp[k]));
        chk("rr_grant_ch", 32'(grant_ch), 32'(rr_exp[k]));
        chk("rr_period", 32'(period), (rr_exp[k] == 0) ? 32'd4 : 32'd8);
      end
      @(posedge clk);
      #1 req[rr_exp[k]] = 1'b0;
      @(posedge clk);
      #1 req[rr_exp[k]] = 1'b1;
    end
    req = '0;
    en[0] = 1'b0;
    en[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Table of averaged / truncated periods
    for (int v = 0; v < 6; v++) run_vec(tbl[v]);

    // Abort: drop req[3] in COUNT; previous result (ch1, 11) must survive
    set_pat(3, 9, 9, 9, 9);
    en[3] = 1'b1;
    @(posedge clk);
    #1 req[3] = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    chk("abort_grant_ch", 32'(grant_ch), 32'd3);
    @(posedge clk);
    #1 req[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_after", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_period_kept", 32'(period), 32'd11);
    chk("abort_done_ch_kept", 32'(done_ch), 32'd1);
    en[3] = 1'b0;

    // Timeout on the narrow instance: ch0 stuck low, cyc runs 0..15 in ARM
    @(posedge clk);
    #1 req2[0] = 1'b1;
    got = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done2) begin
        got = i;
        break;
      end
    end
    chk("to_latency", 32'(got), 32'd18);
    chk("to_period", 32'(period2), 32'd15);
    chk("to_flag", 32'(timeout2), 32'd1);
    chk("to_done_ch", 32'(done_ch2), 32'd0);
    @(posedge clk);
    #1 req2[0] = 1'b0;

    // Narrow instance, single-period measurement clears the timeout flag
    set_pat(1, 6, 6, 6, 6);
    en[1] = 1'b1;
    @(posedge clk);
    #1 req2[1] = 1'b1;
    wait_done2("narrow", ok);
    if (ok) begin
      chk("narrow_period", 32'(period2), 32'd6);
      chk("narrow_timeout", 32'(timeout2), 32'd0);
      chk("narrow_done_ch", 32'(done_ch2), 32'd1);
    end
    @(posedge clk);
    #1;
    req2[1] = 1'b0;
    en[1] = 1'b0;
    repeat (3) @(posedge clk);

    // Asynchronous reset in the middle of COUNT, then a fresh measurement
    set_pat(1, 5, 5, 5, 5);
    en[1] = 1'b1;
    #1 req[1] = 1'b1;
    repeat (15) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_done_ch", 32'(done_ch), 32'd0);
    chk("arst_grant_ch", 32'(grant_ch), 32'd0);
    chk("arst_period", 32'(period), 32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    chk("arst_period2", 32'(period2), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done("post_rst", ok);
    if (ok) begin
      chk("post_rst_done_ch", 32'(done_ch), 32'd1);
      chk("post_rst_period", 32'(period), 32'd5);
      chk("post_rst_timeout", 32'(timeout), 32'd0);
    end
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    en[1] = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
